// File: rtl/mem_rr_arbiter.sv
// mem_rr_arbiter: round-robin arbiter that lets NUM_CONSUMERS requesters share
// one memory read/write channel. One transaction is in flight at a time.
//
// Handshake: a consumer asserts *_valid and holds it, with its address and
// data stable, until it sees a one-cycle *_ready pulse. The transaction is
// then retired once the consumer drops that valid. Toward memory, the arbiter
// holds mem_*_valid with stable address/data until mem_*_ready is sampled
// high, or until the wait counter expires.
module mem_rr_arbiter #(
  parameter int ADDR_BITS      = 8,
  parameter int DATA_BITS      = 16,
  parameter int NUM_CONSUMERS  = 4,
  parameter int WRITE_ENABLE   = 1,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic [NUM_CONSUMERS-1:0]             consumer_read_valid,
  input  logic [NUM_CONSUMERS*ADDR_BITS-1:0]   consumer_read_address,
  output logic [NUM_CONSUMERS-1:0]             consumer_read_ready,
  output logic [NUM_CONSUMERS*DATA_BITS-1:0]   consumer_read_data,
  input  logic [NUM_CONSUMERS-1:0]             consumer_write_valid,
  input  logic [NUM_CONSUMERS*ADDR_BITS-1:0]   consumer_write_address,
  input  logic [NUM_CONSUMERS*DATA_BITS-1:0]   consumer_write_data,
  output logic [NUM_CONSUMERS-1:0]             consumer_write_ready,
  output logic                                 mem_read_valid,
  output logic [ADDR_BITS-1:0]                 mem_read_address,
  input  logic                                 mem_read_ready,
  input  logic [DATA_BITS-1:0]                 mem_read_data,
  output logic                                 mem_write_valid,
  output logic [ADDR_BITS-1:0]                 mem_write_address,
  output logic [DATA_BITS-1:0]                 mem_write_data,
  input  logic                                 mem_write_ready,
  output logic [$clog2(NUM_CONSUMERS)-1:0]     grant_id,
  output logic                                 busy,
  output logic                                 timeout_err,
  output logic [1:0]                           dbg_state
);

  localparam int GW = $clog2(NUM_CONSUMERS);

  typedef enum logic [1:0] {
    S_IDLE       = 2'd0,
    S_READ_WAIT  = 2'd1,
    S_WRITE_WAIT = 2'd2,
    S_RELAY      = 2'd3
  } state_t;

  state_t                 r_state;
  logic [GW-1:0]          r_last_grant;
  logic [GW-1:0]          r_grant_id;
  logic                   r_op_write;
  logic [7:0]             r_wait_cnt;
  logic                   r_busy;
  logic                   r_timeout_err;
  logic                   r_mem_read_valid;
  logic [ADDR_BITS-1:0]   r_mem_read_address;
  logic                   r_mem_write_valid;
  logic [ADDR_BITS-1:0]   r_mem_write_address;
  logic [DATA_BITS-1:0]   r_mem_write_data;
  logic [NUM_CONSUMERS-1:0] r_read_ready;
  logic [NUM_CONSUMERS-1:0] r_write_ready;
  logic [DATA_BITS-1:0]   r_read_data [NUM_CONSUMERS];

  logic [NUM_CONSUMERS-1:0] w_req;
  logic                     w_req_any;
  logic [GW-1:0]            w_sel;
  logic [7:0]               w_wait_next;
  logic                     w_wait_expired;
  logic                     w_served_valid;

  assign w_req          = consumer_read_valid | consumer_write_valid;
  assign w_wait_next    = r_wait_cnt + 8'd1;
  assign w_wait_expired = (w_wait_next == 8'(TIMEOUT_CYCLES));
  assign w_served_valid = r_op_write ? consumer_write_valid[r_grant_id]
                                     : consumer_read_valid[r_grant_id];

  // Round-robin pick: first requester at or after last_grant+1 (wrapping).
  // Iterating from the farthest offset down lets the nearest one win.
  always_comb begin
    logic [GW-1:0] v_idx;
    w_req_any = 1'b0;
    w_sel     = '0;
    v_idx     = '0;
    for (int k = NUM_CONSUMERS - 1; k >= 0; k--) begin
      v_idx = GW'((int'(r_last_grant) + 1 + k) % NUM_CONSUMERS);
      if (w_req[v_idx]) begin
        w_req_any = 1'b1;
        w_sel     = v_idx;
      end
    end
  end

  // Arbiter FSM; every output is a register updated here.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state             <= S_IDLE;
      r_last_grant        <= GW'(NUM_CONSUMERS - 1);
      r_grant_id          <= '0;
      r_op_write          <= 1'b0;
      r_wait_cnt          <= '0;
      r_busy              <= 1'b0;
      r_timeout_err       <= 1'b0;
      r_mem_read_valid    <= 1'b0;
      r_mem_read_address  <= '0;
      r_mem_write_valid   <= 1'b0;
      r_mem_write_address <= '0;
      r_mem_write_data    <= '0;
      r_read_ready        <= '0;
      r_write_ready       <= '0;
      for (int i = 0; i < NUM_CONSUMERS; i++) r_read_data[i] <= '0;
    end else begin
      // Done pulses last exactly one cycle unless re-asserted below.
      r_read_ready  <= '0;
      r_write_ready <= '0;
      case (r_state)
        S_IDLE: begin
          if (w_req_any) begin
            r_grant_id   <= w_sel;
            r_last_grant <= w_sel;
            r_wait_cnt   <= '0;
            r_busy       <= 1'b1;
            if (consumer_read_valid[w_sel]) begin
              // Read wins over a simultaneous write from the same consumer.
              r_op_write         <= 1'b0;
              r_mem_read_valid   <= 1'b1;
              r_mem_read_address <= consumer_read_address[w_sel*ADDR_BITS +: ADDR_BITS];
              r_state            <= S_READ_WAIT;
            end else begin
              r_op_write <= 1'b1;
              if (WRITE_ENABLE != 0) begin
                r_mem_write_valid   <= 1'b1;
                r_mem_write_address <= consumer_write_address[w_sel*ADDR_BITS +: ADDR_BITS];
                r_mem_write_data    <= consumer_write_data[w_sel*DATA_BITS +: DATA_BITS];
                r_state             <= S_WRITE_WAIT;
              end else begin
                // Read-only channel: acknowledge and drop the write.
                r_write_ready[w_sel] <= 1'b1;
                r_state              <= S_RELAY;
              end
            end
          end
        end
        S_READ_WAIT: begin
          if (mem_read_ready) begin
            r_mem_read_valid        <= 1'b0;
            r_read_data[r_grant_id] <= mem_read_data;
            r_read_ready[r_grant_id] <= 1'b1;
            r_state                 <= S_RELAY;
          end else if (w_wait_expired) begin
            r_mem_read_valid         <= 1'b0;
            r_read_data[r_grant_id]  <= '0;
            r_read_ready[r_grant_id] <= 1'b1;
            r_timeout_err            <= 1'b1;
            r_wait_cnt               <= w_wait_next;
            r_state                  <= S_RELAY;
          end else begin
            r_wait_cnt <= w_wait_next;
          end
        end
        S_WRITE_WAIT: begin
          if (mem_write_ready) begin
            r_mem_write_valid         <= 1'b0;
            r_write_ready[r_grant_id] <= 1'b1;
            r_state                   <= S_RELAY;
          end else if (w_wait_expired) begin
            r_mem_write_valid         <= 1'b0;
            r_write_ready[r_grant_id] <= 1'b1;
            r_timeout_err             <= 1'b1;
            r_wait_cnt                <= w_wait_next;
            r_state                   <= S_RELAY;
          end else begin
            r_wait_cnt <= w_wait_next;
          end
        end
        S_RELAY: begin
          // Hold until the served consumer withdraws the granted request.
          if (!w_served_valid) begin
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // Flatten per-consumer read data onto the packed output bus.
  for (genvar g = 0; g < NUM_CONSUMERS; g++) begin : g_rdata
    assign consumer_read_data[g*DATA_BITS +: DATA_BITS] = r_read_data[g];
  end

  assign consumer_read_ready  = r_read_ready;
  assign consumer_write_ready = r_write_ready;
  assign mem_read_valid       = r_mem_read_valid;
  assign mem_read_address     = r_mem_read_address;
  assign mem_write_valid      = r_mem_write_valid;
  assign mem_write_address    = r_mem_write_address;
  assign mem_write_data       = r_mem_write_data;
  assign grant_id             = r_grant_id;
  assign busy                 = r_busy;
  assign timeout_err          = r_timeout_err;
  assign dbg_state            = r_state;

endmodule
